// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration flip-flop chain loader.
package ccff_pkg;

   typedef enum logic {
      CCFF_LOAD     = 1'b0,
      CCFF_READBACK = 1'b1
   } ccff_mode_e;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int words_for_chain(input int len, input int w);
      return (len + w - 1) / w;
   endfunction

endpackage

// File: rtl/ccff_chain_loader_piso.sv
// Word-wide parallel-in/serial-out register, LSB first, with a last-bit flag.
module ccff_piso #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              sout,
   output logic              sout_next,
   output logic              last_bit
);
   localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic [WORD_W-1:0] sreg;
   logic [WORD_W-1:0] sreg_shr;
   logic [POS_W-1:0]  pos;

   assign sreg_shr  = sreg >> 1;
   assign sout      = sreg[0];
   assign sout_next = sreg_shr[0];
   assign last_bit  = (pos == POS_W'(WORD_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         pos  <= '0;
      end else if (load) begin
         sreg <= din;
         pos  <= '0;
      end else if (shift) begin
         sreg <= sreg_shr;
         pos  <= pos + 1'b1;
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Host-side driver that loads or reads back (non-destructively) the ccff chain.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 400,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_clk_en,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [CNT_W-1:0]  mismatch_cnt
);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

   logic [1:0]       state;
   ccff_mode_e       mode_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             head_q;
   logic             sout;
   logic             sout_next;
   logic             last_bit;
   logic             final_bit;
   logic             handshake;
   logic             piso_shift;

   assign final_bit  = (bit_cnt == LAST_IDX);
   assign word_ready = (state == ST_FETCH) ||
                       ((state == ST_SHIFT) && last_bit && !final_bit);
   assign handshake  = word_valid && word_ready;
   assign piso_shift = (state == ST_SHIFT) && !last_bit && !final_bit;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);

   // Readback feeds the tail straight back so CHAIN_LEN shifts rotate the chain to its original contents.
   assign ccff_head  = ((state == ST_SHIFT) && (mode_q == CCFF_READBACK)) ? ccff_tail : head_q;

   ccff_piso #(
      .WORD_W (WORD_W)
   ) u_piso (
      .clk       (prog_clk),
      .rst_n     (prog_reset_n),
      .load      (handshake),
      .shift     (piso_shift),
      .din       (word_data),
      .sout      (sout),
      .sout_next (sout_next),
      .last_bit  (last_bit)
   );

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state        <= ST_IDLE;
         mode_q       <= CCFF_LOAD;
         bit_cnt      <= '0;
         head_q       <= 1'b0;
         chain_clk_en <= 1'b0;
         mismatch     <= 1'b0;
         mismatch_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q       <= mode ? CCFF_READBACK : CCFF_LOAD;
                  mismatch     <= 1'b0;
                  mismatch_cnt <= '0;
                  bit_cnt      <= '0;
                  state        <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (handshake) begin
                  head_q       <= word_data[0];
                  chain_clk_en <= 1'b1;
                  state        <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bit_cnt <= bit_cnt + 1'b1;
               // The tail sampled here is the pre-shift bit, i.e. the next bit of the original stream.
               if ((mode_q == CCFF_READBACK) && (ccff_tail != sout)) begin
                  mismatch <= 1'b1;
                  if (mismatch_cnt != '1) begin
                     mismatch_cnt <= mismatch_cnt + 1'b1;
                  end
               end
               if (final_bit) begin
                  chain_clk_en <= 1'b0;
                  state        <= ST_DONE;
               end else if (last_bit) begin
                  if (handshake) begin
                     head_q <= word_data[0];
                  end else begin
                     chain_clk_en <= 1'b0;
                     state        <= ST_FETCH;
                  end
               end else begin
                  head_q <= sout_next;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: two loaders (12-bit and 4-bit chains) each driving a behavioural DFF chain model.
module tb_ccff_chain_loader;

   logic       prog_clk     = 1'b0;
   logic       prog_reset_n = 1'b0;
   logic       start        = 1'b0;
   logic       mode         = 1'b0;
   logic       word_valid   = 1'b0;
   logic [7:0] word_data    = 8'h00;
   int         sel          = 0;

   logic       a_start, a_valid, a_ready, a_head, a_tail, a_en, a_busy, a_done, a_mis;
   logic [3:0] a_cnt;
   logic       b_start, b_valid, b_ready, b_head, b_tail, b_en, b_busy, b_done, b_mis;
   logic [2:0] b_cnt;
   logic       o_ready, o_head, o_en, o_busy, o_done, o_mis;
   logic [3:0] o_cnt;

   logic [11:0] chain_a = 12'h000;
   logic [3:0]  chain_b = 4'h0;

   int total = 0;
   int bad   = 0;
   int cycles, shifts, accepts, dones, en_low_busy;

   always #5 prog_clk = ~prog_clk;

   assign a_start = start && (sel == 0);
   assign b_start = start && (sel == 1);
   assign a_valid = word_valid && (sel == 0);
   assign b_valid = word_valid && (sel == 1);
   assign a_tail  = chain_a[11];
   assign b_tail  = chain_b[3];

   assign o_ready = (sel == 1) ? b_ready : a_ready;
   assign o_head  = (sel == 1) ? b_head  : a_head;
   assign o_en    = (sel == 1) ? b_en    : a_en;
   assign o_busy  = (sel == 1) ? b_busy  : a_busy;
   assign o_done  = (sel == 1) ? b_done  : a_done;
   assign o_mis   = (sel == 1) ? b_mis   : a_mis;
   assign o_cnt   = (sel == 1) ? {1'b0, b_cnt} : a_cnt;

   // Chain models: bit [N-1] is the tail DFF, the head DFF captures ccff_head on enabled edges.
   always @(posedge prog_clk) begin
      if (a_en) chain_a <= {chain_a[10:0], a_head};
      if (b_en) chain_b <= {chain_b[2:0], b_head};
   end

   ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) dut_a (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .start        (a_start),
      .mode         (mode),
      .word_data    (word_data),
      .word_valid   (a_valid),
      .word_ready   (a_ready),
      .ccff_head    (a_head),
      .ccff_tail    (a_tail),
      .chain_clk_en (a_en),
      .busy         (a_busy),
      .done         (a_done),
      .mismatch     (a_mis),
      .mismatch_cnt (a_cnt)
   );

   ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(4)) dut_b (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .start        (b_start),
      .mode         (mode),
      .word_data    (word_data),
      .word_valid   (b_valid),
      .word_ready   (b_ready),
      .ccff_head    (b_head),
      .ccff_tail    (b_tail),
      .chain_clk_en (b_en),
      .busy         (b_busy),
      .done         (b_done),
      .mismatch     (b_mis),
      .mismatch_cnt (b_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
      end
   endtask

   // One operation from the start pulse up to done (or an abort by reset once rst_at shifts have happened).
   task automatic applyStimulus(input int s, input logic m, input logic [7:0] w0, input logic [7:0] w1,
                                input int stall, input int rst_at, input int start_mid);
      logic [7:0] w [2];
      int idx;
      int stall_left;
      sel = s;
      w[0] = w0;
      w[1] = w1;
      idx = 0;
      stall_left = 0;
      cycles = 0; shifts = 0; accepts = 0; dones = 0; en_low_busy = 0;
      @(negedge prog_clk);
      start = 1'b1;
      mode  = m;
      word_valid = 1'b0;
      for (int it = 1; it <= 200; it++) begin
         @(negedge prog_clk);
         start = (it == start_mid);
         mode  = (it == start_mid) ? 1'b1 : m;
         if (rst_at >= 0 && shifts == rst_at) begin
            prog_reset_n = 1'b0;
            break;
         end
         word_valid = (idx < 2) && (stall_left == 0);
         word_data  = w[(idx > 1) ? 1 : idx];
         if (stall_left > 0) stall_left--;
         #1;
         cycles = it;
         if (o_en) shifts++;
         else if (o_busy) en_low_busy++;
         if (o_done) begin
            dones++;
            break;
         end
         if (word_valid && o_ready) begin
            accepts++;
            idx++;
            if (idx == 1) stall_left = stall;
         end
      end
      start = 1'b0;
      word_valid = 1'b0;
   endtask

   task automatic checkIdleAfter(input string tag);
      @(negedge prog_clk);
      #1;
      checkOutput({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
      checkOutput({tag, "_idle_done"}, 32'(o_done), 32'd0);
   endtask

   initial begin
      #2;
      checkOutput("rst_outs_a", 32'({a_ready, a_head, a_en, a_busy, a_done, a_mis, a_cnt}), 32'd0);
      checkOutput("rst_outs_b", 32'({b_ready, b_head, b_en, b_busy, b_done, b_mis, b_cnt}), 32'd0);
      @(negedge prog_clk);
      prog_reset_n = 1'b1;

      // Plain load, both words held valid: no bubble between words.
      applyStimulus(0, 1'b0, 8'hA5, 8'h03, 0, -1, 0);
      checkOutput("load_cycles", 32'(cycles), 32'd14);
      checkOutput("load_shifts", 32'(shifts), 32'd12);
      checkOutput("load_en_low", 32'(en_low_busy), 32'd2);
      checkOutput("load_accepts", 32'(accepts), 32'd2);
      checkOutput("load_dones", 32'(dones), 32'd1);
      checkOutput("load_chain", 32'(chain_a), 32'hA5C);
      checkIdleAfter("load");

      applyStimulus(0, 1'b1, 8'hA5, 8'h03, 0, -1, 0);
      checkOutput("rb_ok_shifts", 32'(shifts), 32'd12);
      checkOutput("rb_ok_mis", 32'(o_mis), 32'd0);
      checkOutput("rb_ok_cnt", 32'(o_cnt), 32'd0);
      checkOutput("rb_ok_chain", 32'(chain_a), 32'hA5C);

      applyStimulus(0, 1'b1, 8'hA4, 8'h03, 0, -1, 0);
      checkOutput("rb_bad_mis", 32'(o_mis), 32'd1);
      checkOutput("rb_bad_cnt", 32'(o_cnt), 32'd1);
      checkOutput("rb_bad_chain", 32'(chain_a), 32'hA5C);
      checkIdleAfter("rb_bad");
      checkOutput("rb_bad_sticky", 32'(o_mis), 32'd1);

      // Stalled load: five FETCH cycles with nothing offered after the first word.
      applyStimulus(0, 1'b0, 8'h3C, 8'h09, 13, -1, 0);
      checkOutput("stall_cycles", 32'(cycles), 32'd20);
      checkOutput("stall_shifts", 32'(shifts), 32'd12);
      checkOutput("stall_en_low", 32'(en_low_busy), 32'd8);
      checkOutput("stall_chain", 32'(chain_a), 32'h3C9);
      checkOutput("stall_mis_clr", 32'(o_mis), 32'd0);

      applyStimulus(0, 1'b0, 8'hA5, 8'h03, 0, 6, 0);
      #1;
      checkOutput("abort_outs", 32'({o_ready, o_head, o_en, o_busy, o_done, o_mis, o_cnt}), 32'd0);
      checkOutput("abort_chain", 32'(chain_a), 32'h269);
      checkOutput("abort_dones", 32'(dones), 32'd0);
      @(negedge prog_clk);
      prog_reset_n = 1'b1;

      // Reload after the abort, with a stray readback start while busy.
      applyStimulus(0, 1'b0, 8'hA5, 8'h03, 0, -1, 5);
      checkOutput("reload_cycles", 32'(cycles), 32'd14);
      checkOutput("reload_dones", 32'(dones), 32'd1);
      checkOutput("reload_chain", 32'(chain_a), 32'hA5C);
      checkIdleAfter("reload");

      applyStimulus(1, 1'b0, 8'h0F, 8'hF0, 0, -1, 0);
      checkOutput("short_cycles", 32'(cycles), 32'd6);
      checkOutput("short_shifts", 32'(shifts), 32'd4);
      checkOutput("short_accepts", 32'(accepts), 32'd1);
      checkOutput("short_chain", 32'(chain_b), 32'hF);
      checkIdleAfter("short");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
